// File: rtl/sap1_pkg.sv
// sap1_pkg: shared opcodes, step encodings and control-word layout for the SAP-1 sequencer
package sap1_pkg;
    localparam int OPW   = 4;
    localparam int STEPS = 5;
    localparam int CW_W  = 14;

    typedef logic [OPW-1:0]  opcode_t;
    typedef logic [CW_W-1:0] cw_t;
    typedef logic [2:0]      step_t;

    localparam opcode_t OP_NOP = 4'h0;
    localparam opcode_t OP_LDA = 4'h1;
    localparam opcode_t OP_ADD = 4'h2;
    localparam opcode_t OP_SUB = 4'h3;
    localparam opcode_t OP_STA = 4'h4;
    localparam opcode_t OP_LDI = 4'h5;
    localparam opcode_t OP_JMP = 4'h6;
    localparam opcode_t OP_JC  = 4'h7;
    localparam opcode_t OP_JZ  = 4'h8;
    localparam opcode_t OP_OUT = 4'hE;
    localparam opcode_t OP_HLT = 4'hF;

    localparam step_t T0     = 3'd0;
    localparam step_t T1     = 3'd1;
    localparam step_t T2     = 3'd2;
    localparam step_t T3     = 3'd3;
    localparam step_t T4     = 3'd4;
    localparam step_t T_HALT = 3'd5;

    localparam int CW_PC_INC  = 0;
    localparam int CW_PC_OUT  = 1;
    localparam int CW_PC_LD   = 2;
    localparam int CW_MAR_LD  = 3;
    localparam int CW_RAM_OUT = 4;
    localparam int CW_RAM_WR  = 5;
    localparam int CW_IR_LD   = 6;
    localparam int CW_IR_OUT  = 7;
    localparam int CW_A_LD    = 8;
    localparam int CW_A_OUT   = 9;
    localparam int CW_B_LD    = 10;
    localparam int CW_SUB     = 11;
    localparam int CW_SUM_WR  = 12;
    localparam int CW_OUT_LD  = 13;
endpackage

// File: rtl/sap1_control_if.sv
// sap1_ctrl_if: run/opcode/flag inputs and control strobes between sequencer and datapath
interface sap1_ctrl_if;
    import sap1_pkg::*;
    logic    run;
    opcode_t ir_opcode;
    logic    carry_flg, zero_flg;
    logic    pc_inc, pc_out, pc_ld, mar_ld, ram_out, ram_wr, ir_ld, ir_out;
    logic    a_ld, a_out, b_ld, sub, sum_wr, out_ld, halted;
    step_t   t_state;

    modport master (
        input  run, ir_opcode, carry_flg, zero_flg,
        output pc_inc, pc_out, pc_ld, mar_ld, ram_out, ram_wr, ir_ld, ir_out,
               a_ld, a_out, b_ld, sub, sum_wr, out_ld, halted, t_state
    );
    modport slave (
        output run, ir_opcode, carry_flg, zero_flg,
        input  pc_inc, pc_out, pc_ld, mar_ld, ram_out, ram_wr, ir_ld, ir_out,
               a_ld, a_out, b_ld, sub, sum_wr, out_ld, halted, t_state
    );
endinterface

// File: rtl/sap1_ucode_rom.sv
// sap1_ucode_rom: combinational microcode, {opcode, step, flags} -> {last_step, control word}
module sap1_ucode_rom
    import sap1_pkg::*;
(
    input  opcode_t opcode,
    input  step_t   step,
    input  logic    carry,
    input  logic    zero,
    output logic    last_step,
    output cw_t     cw
);
    always_comb begin
        cw        = '0;
        last_step = 1'b0;
        case (step)
            T0: begin
                cw[CW_PC_OUT] = 1'b1;
                cw[CW_MAR_LD] = 1'b1;
            end
            T1: begin
                cw[CW_RAM_OUT] = 1'b1;
                cw[CW_IR_LD]   = 1'b1;
                cw[CW_PC_INC]  = 1'b1;
            end
            T2: begin
                last_step = !(opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_STA});
                cw[CW_IR_OUT] = opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI, OP_JMP, OP_JC, OP_JZ};
                cw[CW_MAR_LD] = opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_STA};
                cw[CW_A_LD]   = opcode == OP_LDI;
                cw[CW_PC_LD]  = opcode == OP_JMP || (opcode == OP_JC && carry) || (opcode == OP_JZ && zero);
                cw[CW_A_OUT]  = opcode == OP_OUT;
                cw[CW_OUT_LD] = opcode == OP_OUT;
            end
            T3: begin
                last_step = !(opcode inside {OP_ADD, OP_SUB});
                cw[CW_RAM_OUT] = opcode inside {OP_LDA, OP_ADD, OP_SUB};
                cw[CW_A_LD]    = opcode == OP_LDA;
                cw[CW_B_LD]    = opcode inside {OP_ADD, OP_SUB};
                cw[CW_A_OUT]   = opcode == OP_STA;
                cw[CW_RAM_WR]  = opcode == OP_STA;
            end
            default: begin
                last_step = 1'b1;
                cw[CW_SUM_WR] = step == T4 && opcode inside {OP_ADD, OP_SUB};
                cw[CW_A_LD]   = step == T4 && opcode inside {OP_ADD, OP_SUB};
                cw[CW_SUB]    = step == T4 && opcode == OP_SUB;
            end
        endcase
    end
endmodule

// File: rtl/sap1_control.sv
// sap1_control: SAP-1 T-state sequencer driving all datapath control strobes
module sap1_control
    import sap1_pkg::*;
(
    input logic         clk,
    input logic         rst_n,
    sap1_ctrl_if.master bus
);
    logic [STEPS-1:0] step;
    logic             halt;
    logic             last;
    step_t            idx;
    cw_t              cw, gated;

    assign idx = step[4] ? T4 : step[3] ? T3 : step[2] ? T2 : step[1] ? T1 : T0;

    sap1_ucode_rom u_rom (
        .opcode    (bus.ir_opcode),
        .step      (idx),
        .carry     (bus.carry_flg),
        .zero      (bus.zero_flg),
        .last_step (last),
        .cw        (cw)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step <= STEPS'(1);
            halt <= 1'b0;
        end else if (bus.run && !halt) begin
            halt <= idx == T2 && bus.ir_opcode == OP_HLT;
            step <= last ? STEPS'(1) : {step[STEPS-2:0], 1'b0};
        end
    end

    // Reset and run gate the strobes combinationally so nothing fires in a reset or paused cycle
    assign gated = cw & {CW_W{bus.run & rst_n & ~halt}};

    assign bus.pc_inc  = gated[CW_PC_INC];
    assign bus.pc_out  = gated[CW_PC_OUT];
    assign bus.pc_ld   = gated[CW_PC_LD];
    assign bus.mar_ld  = gated[CW_MAR_LD];
    assign bus.ram_out = gated[CW_RAM_OUT];
    assign bus.ram_wr  = gated[CW_RAM_WR];
    assign bus.ir_ld   = gated[CW_IR_LD];
    assign bus.ir_out  = gated[CW_IR_OUT];
    assign bus.a_ld    = gated[CW_A_LD];
    assign bus.a_out   = gated[CW_A_OUT];
    assign bus.b_ld    = gated[CW_B_LD];
    assign bus.sub     = gated[CW_SUB];
    assign bus.sum_wr  = gated[CW_SUM_WR];
    assign bus.out_ld  = gated[CW_OUT_LD];
    assign bus.halted  = halt;
    assign bus.t_state = halt ? T_HALT : idx;
endmodule

// File: tb/tb_sap1_control.sv
// tb_sap1_control: scoreboard bench comparing sequencer strobes against a per-opcode step-list model
module tb_sap1_control;
    import sap1_pkg::*;

    typedef struct packed {
        logic [2:0]  t;
        logic        h;
        logic [13:0] cw;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   mk = 0;
    logic mh = 1'b0;
    exp_t q[$];
    logic [13:0] obs;

    sap1_ctrl_if bus ();
    sap1_control dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    assign obs = {bus.out_ld, bus.sum_wr, bus.sub, bus.b_ld, bus.a_out, bus.a_ld, bus.ir_out,
                  bus.ir_ld, bus.ram_wr, bus.ram_out, bus.mar_ld, bus.pc_ld, bus.pc_out, bus.pc_inc};

    function automatic int model_len(input logic [3:0] op);
        if (op == OP_ADD || op == OP_SUB) return 5;
        if (op == OP_LDA || op == OP_STA) return 4;
        return 3;
    endfunction

    function automatic logic [13:0] model_cw(input int k, input logic [3:0] op, input logic c, input logic z);
        logic [13:0] w;
        w = '0;
        if (k == 0) begin
            w[CW_PC_OUT] = 1'b1; w[CW_MAR_LD] = 1'b1;
        end else if (k == 1) begin
            w[CW_RAM_OUT] = 1'b1; w[CW_IR_LD] = 1'b1; w[CW_PC_INC] = 1'b1;
        end else begin
            case (op)
                OP_LDA: if (k == 2) begin w[CW_IR_OUT] = 1'b1; w[CW_MAR_LD] = 1'b1; end
                        else begin w[CW_RAM_OUT] = 1'b1; w[CW_A_LD] = 1'b1; end
                OP_ADD, OP_SUB:
                    if (k == 2) begin w[CW_IR_OUT] = 1'b1; w[CW_MAR_LD] = 1'b1; end
                    else if (k == 3) begin w[CW_RAM_OUT] = 1'b1; w[CW_B_LD] = 1'b1; end
                    else begin w[CW_SUM_WR] = 1'b1; w[CW_A_LD] = 1'b1; w[CW_SUB] = op == OP_SUB; end
                OP_STA: if (k == 2) begin w[CW_IR_OUT] = 1'b1; w[CW_MAR_LD] = 1'b1; end
                        else begin w[CW_A_OUT] = 1'b1; w[CW_RAM_WR] = 1'b1; end
                OP_LDI: begin w[CW_IR_OUT] = 1'b1; w[CW_A_LD] = 1'b1; end
                OP_JMP: begin w[CW_IR_OUT] = 1'b1; w[CW_PC_LD] = 1'b1; end
                OP_JC:  begin w[CW_IR_OUT] = 1'b1; w[CW_PC_LD] = c; end
                OP_JZ:  begin w[CW_IR_OUT] = 1'b1; w[CW_PC_LD] = z; end
                OP_OUT: begin w[CW_A_OUT] = 1'b1; w[CW_OUT_LD] = 1'b1; end
                default: w = '0;
            endcase
        end
        return w;
    endfunction

    // One clock of stimulus: drive inputs, queue the expected response, advance the model
    task automatic cyc(input logic r, input logic ru, input logic [3:0] op, input logic c, input logic z);
        exp_t e;
        rst_n = r;
        bus.run = ru;
        bus.ir_opcode = op;
        bus.carry_flg = c;
        bus.zero_flg = z;
        e.t  = mh ? 3'd5 : 3'(mk);
        e.h  = mh;
        e.cw = (r && ru && !mh) ? model_cw(mk, op, c, z) : '0;
        q.push_back(e);
        if (!r) begin
            mk = 0;
            mh = 1'b0;
        end else if (ru && !mh) begin
            if (mk == 2 && op == OP_HLT) mh = 1'b1;
            mk = (mk + 1 >= model_len(op)) ? 0 : mk + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [3:0] op, input logic c, input logic z);
        cyc(1'b1, 1'b1, op, c, z);
        while (mk != 0 && !mh) cyc(1'b1, 1'b1, op, c, z);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (obs !== e.cw) begin
                errors++;
                $display("FAIL strobes t=%0d got %b exp %b", e.t, obs, e.cw);
            end
            checks++;
            if (bus.t_state !== e.t) begin
                errors++;
                $display("FAIL t_state got %0d exp %0d", bus.t_state, e.t);
            end
            checks++;
            if (bus.halted !== e.h) begin
                errors++;
                $display("FAIL halted got %b exp %b", bus.halted, e.h);
            end
        end
    end

    initial begin
        logic [3:0] rop;
        bus.run = 1'b0;
        bus.ir_opcode = OP_NOP;
        bus.carry_flg = 1'b0;
        bus.zero_flg = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, OP_NOP, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, OP_ADD, 1'b0, 1'b0);
        instr(OP_ADD, 1'b0, 1'b0);
        instr(OP_SUB, 1'b0, 1'b0);
        instr(OP_JC, 1'b0, 1'b1);
        instr(OP_SUB, 1'b1, 1'b1);
        instr(OP_JZ, 1'b0, 1'b1);
        instr(OP_LDI, 1'b0, 1'b0);
        instr(4'hB, 1'b1, 1'b1);
        instr(OP_LDA, 1'b0, 1'b0);
        instr(OP_STA, 1'b0, 1'b0);
        instr(OP_JMP, 1'b0, 1'b0);
        instr(OP_OUT, 1'b0, 1'b0);
        instr(OP_NOP, 1'b0, 1'b0);
        instr(OP_JC, 1'b1, 1'b0);
        instr(OP_JZ, 1'b1, 1'b0);
        repeat (4) cyc(1'b1, 1'b1, OP_ADD, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 1'b0, OP_ADD, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, OP_ADD, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, OP_NOP, 1'b0, 1'b0);
        rop = OP_NOP;
        for (int i = 0; i < 400; i++) begin
            if (mk == 0) rop = 4'($urandom_range(0, 14));
            cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) != 0), rop,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        cyc(1'b0, 1'b1, OP_NOP, 1'b0, 1'b0);
        repeat (4) cyc(1'b1, 1'b1, OP_STA, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, OP_STA, 1'b0, 1'b0);
        instr(OP_LDI, 1'b0, 1'b0);
        instr(OP_HLT, 1'b0, 1'b0);
        repeat (10) cyc(1'b1, 1'b1, 4'($urandom_range(0, 15)), 1'b1, 1'b1);
        cyc(1'b0, 1'b1, OP_NOP, 1'b0, 1'b0);
        instr(OP_LDI, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain left %0d exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
